// File: rtl/gate_pkg.sv
// rtl/gate_pkg.sv - shared opcode encoding for the gate reduction pipeline
package gate_pkg;

   localparam int OP_W = 3;

   typedef enum logic [OP_W-1:0] {
      OP_AND  = 3'd0,
      OP_OR   = 3'd1,
      OP_XOR  = 3'd2,
      OP_NAND = 3'd3,
      OP_NOR  = 3'd4,
      OP_XNOR = 3'd5,
      OP_PASS = 3'd6,
      OP_RSVD = 3'd7
   } op_t;

endpackage

// File: rtl/gate_reduce.sv
// rtl/gate_reduce.sv - combinational bitwise reduction of NUM_IN packed operands
module gate_reduce
   import gate_pkg::*;
#(
   parameter int WIDTH  = 4,
   parameter int NUM_IN = 2
) (
   input  logic [OP_W-1:0]         op,
   input  logic [NUM_IN*WIDTH-1:0] data,
   output logic [WIDTH-1:0]        result,
   output logic                    err
);

   logic [WIDTH-1:0] and_r;
   logic [WIDTH-1:0] or_r;
   logic [WIDTH-1:0] xor_r;

   always_comb begin
      and_r = '1;
      or_r  = '0;
      xor_r = '0;
      for (int k = 0; k < NUM_IN; k++) begin
         and_r = and_r & data[k*WIDTH +: WIDTH];
         or_r  = or_r  | data[k*WIDTH +: WIDTH];
         xor_r = xor_r ^ data[k*WIDTH +: WIDTH];
      end
   end

   // Inverting ops invert the full reduction, never a pairwise chain
   always_comb begin
      result = '0;
      err    = 1'b0;
      case (op_t'(op))
         OP_AND:  result = and_r;
         OP_OR:   result = or_r;
         OP_XOR:  result = xor_r;
         OP_NAND: result = ~and_r;
         OP_NOR:  result = ~or_r;
         OP_XNOR: result = ~xor_r;
         OP_PASS: result = data[WIDTH-1:0];
         default: err    = 1'b1;
      endcase
   end

endmodule

// File: rtl/param_gate_pipe.sv
// rtl/param_gate_pipe.sv - two-stage handshaked gate bank with completion counter
module param_gate_pipe
   import gate_pkg::*;
#(
   parameter int WIDTH  = 4,
   parameter int NUM_IN = 2,
   parameter int CNT_W  = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [OP_W-1:0]         in_op,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic                    out_err,
   output logic [CNT_W-1:0]        txn_count
);

   logic                    s1_valid;
   logic [OP_W-1:0]         s1_op;
   logic [NUM_IN*WIDTH-1:0] s1_data;
   logic                    s2_load;
   logic                    in_fire;
   logic [WIDTH-1:0]        red_result;
   logic                    red_err;

   assign s2_load  = s1_valid & (~out_valid | out_ready);
   assign in_ready = ~s1_valid | s2_load;
   assign in_fire  = in_valid & in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
      end else if (in_fire) begin
         s1_valid <= 1'b1;
      end else if (s2_load) begin
         s1_valid <= 1'b0;
      end
   end

   // Payload only moves on an accepted handshake, so idle-bus X never lands here
   always_ff @(posedge clk) begin
      if (in_fire) begin
         s1_op   <= in_op;
         s1_data <= in_data;
      end
   end

   gate_reduce #(
      .WIDTH  (WIDTH),
      .NUM_IN (NUM_IN)
   ) u_reduce (
      .op     (s1_op),
      .data   (s1_data),
      .result (red_result),
      .err    (red_err)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_err   <= 1'b0;
      end else if (s2_load) begin
         out_valid <= 1'b1;
         out_data  <= red_result;
         out_err   <= red_err;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         txn_count <= '0;
      end else if (out_valid & out_ready) begin
         txn_count <= txn_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_param_gate_pipe.sv
// tb/tb_param_gate_pipe.sv - scoreboard bench for param_gate_pipe
module tb_param_gate_pipe;

   localparam int W  = 4;
   localparam int NI = 3;
   localparam int CW = 2;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [2:0]        in_op = '0;
   logic [NI*W-1:0]   in_data = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [W-1:0]      out_data;
   logic              out_err;
   logic [CW-1:0]     txn_count;

   param_gate_pipe #(.WIDTH(W), .NUM_IN(NI), .CNT_W(CW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_err   (out_err),
      .txn_count (txn_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] d;
      logic         e;
      int           cyc;
      bit           lat;
   } exp_t;

   exp_t         q[$];
   int           n_cmp = 0;
   int           n_fail = 0;
   int           cyc = 0;
   int           done = 0;
   int           ready_mode = 0;
   bit           lat_mode = 0;
   bit           cur_use = 0;
   logic [W:0]   cur_exp = '0;
   bit           prev_stall = 0;
   logic [W-1:0] prev_d;
   logic         prev_e;
   bit           bp_sent = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic fail(input string name);
      n_cmp++;
      n_fail++;
      $display("FAIL %s actual=timeout required=progress at t=%0t", name, $time);
   endtask

   // Per-bit count of ones decides every gate: all ones, any one, odd parity
   function automatic logic [W:0] ref_model(input logic [2:0] op, input logic [NI*W-1:0] d);
      logic [W-1:0] r;
      int ones;
      for (int b = 0; b < W; b++) begin
         ones = 0;
         for (int k = 0; k < NI; k++) if (d[k*W+b]) ones++;
         case (op)
            3'd0:    r[b] = (ones == NI);
            3'd1:    r[b] = (ones > 0);
            3'd2:    r[b] = (ones % 2 == 1);
            3'd3:    r[b] = !(ones == NI);
            3'd4:    r[b] = (ones == 0);
            3'd5:    r[b] = (ones % 2 == 0);
            3'd6:    r[b] = d[b];
            default: r[b] = 1'b0;
         endcase
      end
      return {op == 3'd7, r};
   endfunction

   always @(posedge clk) cyc++;

   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0:       out_ready = 1'b0;
         1:       out_ready = 1'b1;
         default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
   end

   // Stimulus side: check in_ready against in-flight depth, log accepted work
   always @(negedge clk) begin
      if (!rst) begin
         chk("in_ready", 32'(in_ready), 32'((q.size() < 2) || out_ready));
         if (in_valid && in_ready) begin
            exp_t e;
            logic [W:0] x;
            x = cur_use ? cur_exp : ref_model(in_op, in_data);
            e.d = x[W-1:0];
            e.e = x[W];
            e.cyc = cyc;
            e.lat = lat_mode;
            q.push_back(e);
         end
      end
   end

   always @(negedge clk) begin
      #1;
      if (rst) begin
         prev_stall = 0;
      end else begin
         if (prev_stall) begin
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_data", 32'(out_data), 32'(prev_d));
            chk("stall_err", 32'(out_err), 32'(prev_e));
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               chk("unexpected_output", 32'(out_data), 32'hdead);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("out_data", 32'(out_data), 32'(e.d));
               chk("out_err", 32'(out_err), 32'(e.e));
               chk("txn_count", 32'(txn_count), 32'(done % (1 << CW)));
               if (e.lat) chk("latency", 32'(cyc - e.cyc), 32'd2);
            end
            done++;
         end
         prev_stall = out_valid && !out_ready;
         prev_d = out_data;
         prev_e = out_err;
      end
   end

   task automatic send(input logic [2:0] op, input logic [NI*W-1:0] d,
                       input bit use_exp, input logic [W:0] exp);
      in_op = op;
      in_data = d;
      cur_use = use_exp;
      cur_exp = exp;
      in_valid = 1'b1;
      for (int t = 0; t < 500; t++) begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            in_data = 'x;
            return;
         end
      end
      fail("send_timeout");
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int t = 0; t < 1000; t++) begin
         @(negedge clk);
         #2;
         if (q.size() == 0 && !out_valid) return;
      end
      fail("drain_timeout");
   endtask

   task automatic pulse_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      q.delete();
      done = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [NI*W-1:0] d;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_out_err", 32'(out_err), 32'd0);
      chk("rst_txn_count", 32'(txn_count), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);

      // Directed vectors, sink always ready, exact latency checked
      @(posedge clk);
      #1;
      ready_mode = 1;
      repeat (2) @(posedge clk);
      #1;
      lat_mode = 1;
      send(3'd1, {4'b0000, 4'b0011, 4'b0101}, 1, 5'b0_0111);
      send(3'd3, {4'b1111, 4'b0011, 4'b0101}, 1, 5'b0_1110);
      send(3'd2, {4'b0110, 4'b1010, 4'b1111}, 1, 5'b0_0011);
      send(3'd5, {4'b0110, 4'b1010, 4'b1111}, 1, 5'b0_1100);
      send(3'd7, {4'b1111, 4'b1111, 4'b1111}, 1, 5'b1_0000);
      send(3'd6, {4'b0000, 4'b1111, 4'b1001}, 1, 5'b0_1001);
      // All 8 operand bit-combinations across two beats for every op
      for (int op = 0; op < 7; op++) begin
         for (int t = 0; t < 2; t++) begin
            for (int b = 0; b < W; b++) begin
               for (int k = 0; k < NI; k++) d[k*W+b] = 1'((b + 4*t) >> k);
            end
            send(3'(op), d, 0, '0);
         end
      end
      drain();
      lat_mode = 0;

      // Backpressure: third transaction must wait for the sink
      pulse_reset();
      ready_mode = 0;
      fork
         begin
            send(3'd0, 12'hABC, 0, '0);
            send(3'd1, 12'h123, 0, '0);
            send(3'd2, 12'h5F0, 0, '0);
            bp_sent = 1;
         end
      join_none
      repeat (6) @(posedge clk);
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      ready_mode = 1;
      for (int t = 0; t < 100 && !bp_sent; t++) @(posedge clk);
      if (!bp_sent) fail("bp_send_wait");
      drain();
      chk("bp_txn_count", 32'(txn_count), 32'd3);

      // Counter wrap
      pulse_reset();
      ready_mode = 1;
      for (int i = 0; i < 5; i++) send(3'(i), 12'($urandom), 0, '0);
      drain();
      chk("wrap_txn_count", 32'(txn_count), 32'd1);

      // Reset with two transactions pending
      ready_mode = 0;
      @(posedge clk);
      #1;
      send(3'd1, 12'h111, 0, '0);
      send(3'd2, 12'h222, 0, '0);
      repeat (2) @(posedge clk);
      pulse_reset();
      @(negedge clk);
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_txn_count", 32'(txn_count), 32'd0);
      chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
      ready_mode = 1;
      repeat (6) @(posedge clk);
      @(negedge clk);
      chk("mid_rst_no_stale", 32'(out_valid), 32'd0);

      // Randomized traffic with random sink stalls
      ready_mode = 2;
      for (int i = 0; i < 200; i++) begin
         send(3'($urandom_range(0, 7)), 12'($urandom), 0, '0);
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
      end
      ready_mode = 1;
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/param_gate_pipe.md
Name: param_gate_pipe

Overview:
Parametrised, pipelined bitwise logic unit. It is the next-generation successor to the single two-input gate cells. Each transaction is accepted over a valid/ready handshake and carries NUM_IN operands of WIDTH bits plus an opcode. The unit reduces all operands bitwise under the selected operation and returns the result two cycles later through a stall-capable output handshake. It sits between stimulus/data sources and consumers anywhere a configurable registered gate bank is needed.

Parameters:
WIDTH, 4, bit width of each operand and of the result.
NUM_IN, 2, number of operands reduced per transaction (legal range 2..8).
CNT_W, 8, width of the completed-transaction counter.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  source offers a transaction.
in_ready  output  1  unit can accept a transaction this cycle.
in_op  input  3  opcode, sampled on input handshake.
in_data  input  NUM_IN*WIDTH  packed operands; operand k = in_data[k*WIDTH +: WIDTH].
out_valid  output  1  result is available.
out_ready  input  1  sink accepts the result.
out_data  output  WIDTH  reduced result.
out_err  output  1  result came from the reserved opcode.
txn_count  output  CNT_W  number of completed output handshakes.

Behaviour:
- Opcodes:
  - 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR: reduce across all NUM_IN operands. NAND/NOR/XNOR are the inverse of the full reduction, not pairwise.
  - 6 PASS: output operand 0.
  - 7 reserved: out_data = 0 and out_err = 1.
- Handshakes: input accepted when in_valid & in_ready; output completes when out_valid & out_ready.
- Pipeline: S1 input register (op plus operands), S2 result register. The reduction is combinational between S1 and S2.
- Advance rules:
  - S2 loads when S1 is valid and (S2 is empty or out_ready).
  - S1 loads on the input handshake.
  - in_ready = !s1_valid | s2 can load. This is purely a function of registered state and out_ready; it never depends on in_valid.
- Latency: with out_ready held high, out_valid asserts 2 cycles after the accepting edge. Throughput is 1 transaction per cycle.
- Stall: while out_valid & !out_ready, out_data and out_err stay stable.
  - S1 holds its content.
  - in_ready deasserts once S1 is full, so at most 2 transactions are in flight.
  - No transaction is lost or duplicated.
- Simultaneous events: an output handshake and an input handshake in the same cycle both take effect (shift-through).
- Counter: txn_count increments by 1 on each output handshake and wraps from 2^CNT_W-1 to 0.
- Reset:
  - S1/S2 valids are cleared, out_valid = 0, out_data = 0, out_err = 0, txn_count = 0.
  - in_ready is 1 in the first cycle after reset.
  - Reset asserted mid-operation discards in-flight transactions without producing any output handshake.
- Inputs are don't-care when in_valid = 0. X on in_data must not propagate into registered state unless accepted.

Decomposition:
- Package gate_pkg: op_t enum (OP_AND..OP_PASS, OP_RSVD) as 3-bit localparams, and the OP_W constant.
- Sub-module gate_reduce: purely combinational, parameters WIDTH and NUM_IN; inputs op and packed data; outputs result and err. It is instantiated between S1 and S2 and can also be reused standalone.

Test Plan:
- WIDTH=4, NUM_IN=2, out_ready=1; send op=1 with operand0=0101, operand1=0011 → out_data=0111 and out_err=0 exactly 2 cycles after accept; then op=3 with the same operands → 1110.
- Truth-table sweep, WIDTH=1, NUM_IN=2, all 4 {a,b} pairs × ops 0..6 → results match the gate tables; op=7 → out_data=0, out_err=1.
- NUM_IN=3, op=2 on 1111, 1010, 0110 → 0011; op=5 on the same operands → 1100.
- Backpressure: hold out_ready=0 and send 3 back-to-back transactions → in_ready drops after the 2nd accept and out_data stays stable. Release out_ready → outputs appear in order with no loss; txn_count=3.
- Counter wrap: CNT_W=2, complete 5 transactions → txn_count sequence 1, 2, 3, 0, 1.
- Reset mid-flight: with 2 transactions pending and out_ready=0, pulse rst for 1 cycle → out_valid=0, txn_count=0, in_ready=1 on the next cycle, and no stale result is ever emitted.
